// File: rtl/scrypt_scratch_ctrl_if.sv
// Bundles the core-side handshakes and the SRAM wrapper port of the ROMix
// scratchpad controller. The controller uses the slave modport; the core/SRAM
// side uses the master modport.
interface scrypt_scratch_if #(
  parameter int BLOCK_BITS = 1024,
  parameter int ADDR_BITS  = 17,
  parameter int REC_W      = 1
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [BLOCK_BITS-1:0] wr_data;
  logic                  rd_req;
  logic                  rd_ready;
  logic [31:0]           rd_index;
  logic                  rd_valid;
  logic [BLOCK_BITS-1:0] rd_data;
  logic [REC_W-1:0]      rd_recompute;
  logic                  scratch_read;
  logic                  scratch_write;
  logic [ADDR_BITS-1:0]  scratch_addr;
  logic [BLOCK_BITS-1:0] scratch_in;
  logic [BLOCK_BITS-1:0] scratch_out;

  modport master (
    output start, wr_valid, wr_data, rd_req, rd_index, scratch_out,
    input  busy, done, wr_ready, rd_ready, rd_valid, rd_data, rd_recompute,
           scratch_read, scratch_write, scratch_addr, scratch_in
  );

  modport slave (
    input  start, wr_valid, wr_data, rd_req, rd_index, scratch_out,
    output busy, done, wr_ready, rd_ready, rd_valid, rd_data, rd_recompute,
           scratch_read, scratch_write, scratch_addr, scratch_in
  );
endinterface

// File: rtl/scrypt_scratch_ctrl.sv
// ROMix scratchpad controller: sequences V-block writes during fill and
// integerify-indexed reads during lookup, optionally storing only every
// 2^GAP_LOG2-th block and reporting the recompute count for the core.
module scrypt_scratch_ctrl #(
  parameter int N_LOG2      = 10,
  parameter int GAP_LOG2    = 0,
  parameter int BLOCK_BITS  = 1024,
  parameter int ADDR_BITS   = 17,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_STRIDE = 1,
  parameter int SRAM_RD_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  scrypt_scratch_if.slave bus
);

  localparam int REC_W = (GAP_LOG2 > 0) ? GAP_LOG2 : 1;
  localparam int LAT_W = $clog2(SRAM_RD_LAT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_LOOKUP  = 2'd2;
  localparam logic [1:0] S_WAIT_RD = 2'd3;

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;
  localparam logic [N_LOG2-1:0] GAP_MASK = N_LOG2'((64'd1 << GAP_LOG2) - 64'd1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(SRAM_RD_LAT - 1);
  localparam logic [LAT_W-1:0]  LAT_DONE = LAT_W'(SRAM_RD_LAT);

  if (GAP_LOG2 > N_LOG2 || GAP_LOG2 < 0 || SRAM_RD_LAT < 1 || N_LOG2 < 1) begin : g_bad_cfg
    $error("scrypt_scratch_ctrl: illegal GAP_LOG2/N_LOG2/SRAM_RD_LAT combination");
  end

  // Slot address of block index idx; arithmetic wraps in ADDR_BITS.
  function automatic logic [ADDR_BITS-1:0] slot_addr(input logic [N_LOG2-1:0] idx);
    logic [N_LOG2-1:0] slot;
    slot = idx >> GAP_LOG2;
    return ADDR_BITS'(BASE_ADDR) + ADDR_BITS'(slot) * ADDR_BITS'(ADDR_STRIDE);
  endfunction

  // Number of Salsa iterations needed to rebuild V_j from its stored ancestor.
  function automatic logic [REC_W-1:0] rem_of(input logic [N_LOG2-1:0] idx);
    if (GAP_LOG2 == 0) return '0;
    return REC_W'(idx & GAP_MASK);
  endfunction

  logic [1:0]            state;
  logic [N_LOG2-1:0]     fill_cnt;
  logic [N_LOG2-1:0]     look_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [REC_W-1:0]      rem_p0;
  logic                  scr_wr;
  logic                  scr_rd;
  logic [ADDR_BITS-1:0]  scr_addr;
  logic [BLOCK_BITS-1:0] scr_din;
  logic                  vld_p1;
  logic                  done_p1;
  logic [BLOCK_BITS-1:0] rd_data_p1;
  logic [REC_W-1:0]      rec_p1;

  logic [N_LOG2-1:0] j_idx;
  logic              wr_hs;
  logic              rd_hs;
  logic              slot_aligned;
  logic              capture;
  logic              unused_index_bits;

  assign j_idx             = bus.rd_index[N_LOG2-1:0];
  assign unused_index_bits = ^bus.rd_index;
  assign wr_hs             = bus.wr_valid && (state == S_FILL) && !bus.start;
  assign rd_hs             = bus.rd_req && (state == S_LOOKUP) && !bus.start;
  assign slot_aligned      = ((fill_cnt & GAP_MASK) == '0);
  assign capture           = (state == S_WAIT_RD) && (lat_cnt == LAT_LAST) && !bus.start;

  assign bus.busy          = (state != S_IDLE);
  assign bus.wr_ready      = (state == S_FILL);
  assign bus.rd_ready      = (state == S_LOOKUP);
  assign bus.done          = done_p1;
  assign bus.rd_valid      = vld_p1;
  assign bus.rd_data       = rd_data_p1;
  assign bus.rd_recompute  = rec_p1;
  assign bus.scratch_read  = scr_rd;
  assign bus.scratch_write = scr_wr;
  assign bus.scratch_addr  = scr_addr;
  assign bus.scratch_in    = scr_din;

  // FSM, counters and SRAM command sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fill_cnt <= '0;
      look_cnt <= '0;
      lat_cnt  <= '0;
      rem_p0   <= '0;
      scr_wr   <= 1'b0;
      scr_rd   <= 1'b0;
      scr_addr <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      scr_wr  <= 1'b0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (bus.start) begin
        state    <= S_FILL;
        fill_cnt <= '0;
        look_cnt <= '0;
        lat_cnt  <= '0;
        scr_rd   <= 1'b0;
      end else begin
        case (state)
          S_FILL: begin
            if (wr_hs) begin
              fill_cnt <= fill_cnt + 1'b1;
              if (slot_aligned) begin
                scr_wr   <= 1'b1;
                scr_addr <= slot_addr(fill_cnt);
              end
              if (fill_cnt == LAST_IDX) state <= S_LOOKUP;
            end
          end
          S_LOOKUP: begin
            if (rd_hs) begin
              scr_rd   <= 1'b1;
              scr_addr <= slot_addr(j_idx);
              rem_p0   <= rem_of(j_idx);
              lat_cnt  <= '0;
              state    <= S_WAIT_RD;
            end
          end
          S_WAIT_RD: begin
            lat_cnt <= lat_cnt + 1'b1;
            if (lat_cnt == LAT_LAST) begin
              scr_rd   <= 1'b0;
              vld_p1   <= 1'b1;
              done_p1  <= (look_cnt == LAST_IDX);
              look_cnt <= look_cnt + 1'b1;
            end
            // rd_valid cycle: leave to IDLE after the last lookup
            if (lat_cnt == LAT_DONE) state <= done_p1 ? S_IDLE : S_LOOKUP;
          end
          default: ;
        endcase
      end
    end
  end

  // Write-data and read-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_din    <= '0;
      rd_data_p1 <= '0;
      rec_p1     <= '0;
    end else begin
      if (wr_hs && slot_aligned) scr_din <= bus.wr_data;
      if (capture) begin
        rd_data_p1 <= bus.scratch_out;
        rec_p1     <= rem_p0;
      end
    end
  end

endmodule

// File: tb/tb_scrypt_scratch_ctrl.sv
// Directed bench for scrypt_scratch_ctrl: three configurations sharing one
// clock and reset, each with a simple SRAM model behind it.
module tb_scrypt_scratch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // A: N=16, no gap, LAT 1.  B: N=16, gap 4, LAT 1.  C: N=16, no gap, LAT 3, base 0x100, stride 2.
  scrypt_scratch_if #(.BLOCK_BITS(32), .ADDR_BITS(10), .REC_W(1)) ia ();
  scrypt_scratch_if #(.BLOCK_BITS(32), .ADDR_BITS(10), .REC_W(2)) ib ();
  scrypt_scratch_if #(.BLOCK_BITS(32), .ADDR_BITS(10), .REC_W(1)) ic ();

  scrypt_scratch_ctrl #(.N_LOG2(4), .GAP_LOG2(0), .BLOCK_BITS(32), .ADDR_BITS(10),
    .BASE_ADDR(0), .ADDR_STRIDE(1), .SRAM_RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  scrypt_scratch_ctrl #(.N_LOG2(4), .GAP_LOG2(2), .BLOCK_BITS(32), .ADDR_BITS(10),
    .BASE_ADDR(0), .ADDR_STRIDE(1), .SRAM_RD_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  scrypt_scratch_ctrl #(.N_LOG2(4), .GAP_LOG2(0), .BLOCK_BITS(32), .ADDR_BITS(10),
    .BASE_ADDR(256), .ADDR_STRIDE(2), .SRAM_RD_LAT(3)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  // SRAM models: data is only valid in the last cycle of a held read.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] mem_c [0:1023];
  int rcnt_a = 0, rcnt_b = 0, rcnt_c = 0;
  int wcnt_b = 0;
  int ovl_a = 0, ovl_b = 0, ovl_c = 0;

  always @(posedge clk) begin
    if (ia.scratch_write) mem_a[ia.scratch_addr] <= ia.scratch_in;
    rcnt_a <= ia.scratch_read ? rcnt_a + 1 : 0;
    if (ia.scratch_read && ia.scratch_write) ovl_a <= ovl_a + 1;
  end
  always @(posedge clk) begin
    if (ib.scratch_write) begin
      mem_b[ib.scratch_addr] <= ib.scratch_in;
      wcnt_b <= wcnt_b + 1;
    end
    rcnt_b <= ib.scratch_read ? rcnt_b + 1 : 0;
    if (ib.scratch_read && ib.scratch_write) ovl_b <= ovl_b + 1;
  end
  always @(posedge clk) begin
    if (ic.scratch_write) mem_c[ic.scratch_addr] <= ic.scratch_in;
    rcnt_c <= ic.scratch_read ? rcnt_c + 1 : 0;
    if (ic.scratch_read && ic.scratch_write) ovl_c <= ovl_c + 1;
  end
  assign ia.scratch_out = (ia.scratch_read && rcnt_a == 0) ? mem_a[ia.scratch_addr] : 32'hDEAD_BEEF;
  assign ib.scratch_out = (ib.scratch_read && rcnt_b == 0) ? mem_b[ib.scratch_addr] : 32'hDEAD_BEEF;
  assign ic.scratch_out = (ic.scratch_read && rcnt_c == 2) ? mem_c[ic.scratch_addr] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int wb0;
    int seen;
    ia.start = 0; ia.wr_valid = 0; ia.wr_data = 0; ia.rd_req = 0; ia.rd_index = 0;
    ib.start = 0; ib.wr_valid = 0; ib.wr_data = 0; ib.rd_req = 0; ib.rd_index = 0;
    ic.start = 0; ic.wr_valid = 0; ic.wr_data = 0; ic.rd_req = 0; ic.rd_index = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ia.busy, 0);
    chk("rst_wr_ready", ia.wr_ready, 0);
    chk("rst_rd_ready", ia.rd_ready, 0);
    chk("rst_rd_valid", ia.rd_valid, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_swrite", ia.scratch_write, 0);
    chk("rst_sread", ia.scratch_read, 0);
    chk("rst_saddr", ia.scratch_addr, 0);
    chk("rst_rd_data", ia.rd_data, 0);
    chk("rst_b_rec", ib.rd_recompute, 0);
    rst = 0;
    tick();
    ia.wr_valid = 1;
    tick();
    chk("idle_wr_ignored", ia.scratch_write, 0);
    ia.wr_valid = 0;

    // A: back-to-back fill, one write per cycle to addresses 0..15
    ia.start = 1;
    tick();
    ia.start = 0;
    chk("a_busy", ia.busy, 1);
    chk("a_wr_ready", ia.wr_ready, 1);
    for (int i = 0; i < 16; i++) begin
      ia.wr_valid = 1;
      ia.wr_data = i;
      tick();
      chk("a_fill_wr", ia.scratch_write, 1);
      chk("a_fill_addr", ia.scratch_addr, i);
      chk("a_fill_din", ia.scratch_in, i);
    end
    ia.wr_valid = 0;
    chk("a_rd_ready_after_fill", ia.rd_ready, 1);
    chk("a_wr_ready_after_fill", ia.wr_ready, 0);

    // A: lookup of 0x13 -> slot 3
    ia.rd_req = 1;
    ia.rd_index = 32'h0000_0013;
    tick();
    ia.rd_req = 0;
    chk("a_sread", ia.scratch_read, 1);
    chk("a_saddr", ia.scratch_addr, 3);
    chk("a_rd_ready_wait", ia.rd_ready, 0);
    chk("a_no_early_valid", ia.rd_valid, 0);
    tick();
    chk("a_rd_valid", ia.rd_valid, 1);
    chk("a_rd_data", ia.rd_data, 3);
    chk("a_rd_rec", ia.rd_recompute, 0);
    chk("a_sread_off", ia.scratch_read, 0);
    chk("a_rd_ready_on_valid", ia.rd_ready, 0);
    chk("a_done_first", ia.done, 0);
    tick();
    chk("a_valid_pulse", ia.rd_valid, 0);
    chk("a_rd_ready_back", ia.rd_ready, 1);
    chk("a_rd_data_hold", ia.rd_data, 3);

    // A: remaining 15 lookups, done only with the 16th
    for (int k = 1; k < 16; k++) begin
      ia.rd_req = 1;
      ia.rd_index = 32'hABCD_0000 | k;
      tick();
      ia.rd_req = 0;
      tick();
      chk("a_pass_valid", ia.rd_valid, 1);
      chk("a_pass_data", ia.rd_data, k);
      chk("a_pass_done", ia.done, (k == 15));
      chk("a_pass_busy", ia.busy, 1);
      tick();
    end
    chk("a_busy_after_done", ia.busy, 0);
    chk("a_rd_ready_after_done", ia.rd_ready, 0);
    chk("a_done_pulse", ia.done, 0);
    ia.rd_req = 1;
    tick();
    chk("a_idle_rd_ignored", ia.scratch_read, 0);
    ia.rd_req = 0;

    // B: gap 4, only V0, V4, V8, V12 stored
    wb0 = wcnt_b;
    ib.start = 1;
    tick();
    ib.start = 0;
    for (int i = 0; i < 16; i++) begin
      ib.wr_valid = 1;
      ib.wr_data = 32'h100 + i;
      tick();
      chk("b_fill_wr", ib.scratch_write, (i % 4 == 0));
      if (i % 4 == 0) begin
        chk("b_fill_addr", ib.scratch_addr, i / 4);
        chk("b_fill_din", ib.scratch_in, 32'h100 + i);
      end
    end
    ib.wr_valid = 0;
    tick();
    chk("b_write_count", wcnt_b - wb0, 4);
    for (int s = 0; s < 4; s++) chk("b_mem", mem_b[s], 32'h100 + 4 * s);
    chk("b_rd_ready", ib.rd_ready, 1);
    ib.rd_req = 1;
    ib.rd_index = 14;
    tick();
    ib.rd_req = 0;
    chk("b_sread", ib.scratch_read, 1);
    chk("b_saddr", ib.scratch_addr, 3);
    tick();
    chk("b_rd_valid", ib.rd_valid, 1);
    chk("b_rd_data", ib.rd_data, 32'h10C);
    chk("b_rd_rec", ib.rd_recompute, 2);
    tick();

    // B: start wins over a coincident write handshake
    ib.start = 1;
    tick();
    ib.wr_valid = 1;
    ib.wr_data = 32'h77;
    tick();
    chk("b_start_wr_no_write", ib.scratch_write, 0);
    chk("b_start_fill", ib.wr_ready, 1);
    ib.start = 0;
    ib.wr_data = 32'h200;
    tick();
    chk("b_restart_wr", ib.scratch_write, 1);
    chk("b_restart_addr", ib.scratch_addr, 0);
    chk("b_restart_din", ib.scratch_in, 32'h200);
    ib.wr_data = 32'h201;
    tick();
    chk("b_restart_gap", ib.scratch_write, 0);
    ib.wr_valid = 0;

    // C: base 0x100, stride 2, read latency 3
    ic.start = 1;
    tick();
    ic.start = 0;
    for (int i = 0; i < 16; i++) begin
      ic.wr_valid = 1;
      ic.wr_data = 32'h300 + i;
      tick();
      chk("c_fill_addr", ic.scratch_addr, 32'h100 + 2 * i);
    end
    ic.wr_valid = 0;
    ic.rd_req = 1;
    ic.rd_index = 5;
    tick();
    ic.rd_req = 0;
    for (int c = 1; c <= 3; c++) begin
      chk("c_sread_held", ic.scratch_read, 1);
      chk("c_saddr_held", ic.scratch_addr, 32'h10A);
      chk("c_no_early_valid", ic.rd_valid, 0);
      tick();
    end
    chk("c_rd_valid", ic.rd_valid, 1);
    chk("c_rd_data", ic.rd_data, 32'h305);
    chk("c_sread_off", ic.scratch_read, 0);
    tick();
    chk("c_rd_ready_back", ic.rd_ready, 1);

    // C: start during WAIT_RD drops the read
    ic.rd_req = 1;
    ic.rd_index = 7;
    tick();
    ic.rd_req = 0;
    chk("c_abort_sread", ic.scratch_read, 1);
    ic.start = 1;
    tick();
    ic.start = 0;
    chk("c_abort_sread_off", ic.scratch_read, 0);
    chk("c_abort_fill", ic.wr_ready, 1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (ic.rd_valid) seen++;
      tick();
    end
    chk("c_abort_no_valid", seen, 0);
    ic.wr_valid = 1;
    ic.wr_data = 32'h400;
    tick();
    chk("c_abort_next_wr", ic.scratch_write, 1);
    chk("c_abort_next_addr", ic.scratch_addr, 32'h100);
    ic.wr_valid = 0;

    // A mid-WAIT_RD and C mid-FILL, then asynchronous reset
    ia.start = 1;
    tick();
    ia.start = 0;
    for (int i = 0; i < 16; i++) begin
      ia.wr_valid = 1;
      ia.wr_data = 32'h50 + i;
      tick();
    end
    ia.wr_valid = 0;
    ia.rd_req = 1;
    ia.rd_index = 2;
    ic.wr_valid = 1;
    ic.wr_data = 32'h401;
    tick();
    ia.rd_req = 0;
    chk("pre_rst_a_sread", ia.scratch_read, 1);
    chk("pre_rst_c_swrite", ic.scratch_write, 1);
    chk("pre_rst_a_rd_data", ia.rd_data, 15);
    #2 rst = 1;
    #1;
    chk("arst_a_sread", ia.scratch_read, 0);
    chk("arst_a_busy", ia.busy, 0);
    chk("arst_a_saddr", ia.scratch_addr, 0);
    chk("arst_a_rd_data", ia.rd_data, 0);
    chk("arst_c_swrite", ic.scratch_write, 0);
    chk("arst_c_wr_ready", ic.wr_ready, 0);
    chk("arst_c_sin", ic.scratch_in, 0);
    @(posedge clk);
    #1 rst = 0;
    ia.rd_req = 1;
    tick();
    tick();
    chk("post_rst_a_rd_ignored", ia.scratch_read, 0);
    chk("post_rst_a_rd_ready", ia.rd_ready, 0);
    chk("post_rst_c_wr_ignored", ic.scratch_write, 0);
    chk("post_rst_c_wr_ready", ic.wr_ready, 0);
    ia.rd_req = 0;
    ic.wr_valid = 0;

    chk("no_rw_overlap", ovl_a + ovl_b + ovl_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
